// File: rtl/a0_trace_fifo.sv
// a0 change tracer: records each new a0 value in a first-word fall-through FIFO drained over valid/ready.
// Optional per-entry cycle timestamps (out_time port) are enabled by defining A0_TRACE_TIMESTAMP_EN.
module a0_trace_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] a0_in,
   input  logic                  capture_en,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [PTR_WIDTH:0]    count,
   output logic                  full,
   output logic                  overflow
`ifdef A0_TRACE_TIMESTAMP_EN
   ,
   output logic [31:0]           out_time
`endif
);

   localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] last_q;
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [PTR_WIDTH:0]    count_q;
   logic                  overflow_q;

   logic change;
   logic pop;
   logic push;
   logic drop;

   // A change that finds the FIFO full is only rescued by a simultaneous pop.
   always_comb begin
      change = capture_en && (a0_in != last_q);
      pop    = out_valid && out_ready;
      push   = change && (!full || pop);
      drop   = change && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (change)
            last_q <= a0_in;
         if (push)
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         if (push && !pop)
            count_q <= count_q + (PTR_WIDTH + 1)'(1);
         else if (pop && !push)
            count_q <= count_q - (PTR_WIDTH + 1)'(1);
         if (drop)
            overflow_q <= 1'b1;
      end
   end

   // Storage is cleared on reset so the head reads zero rather than stale data.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= a0_in;
      end
   end

`ifdef A0_TRACE_TIMESTAMP_EN
   logic [31:0] cycle_cnt;
   logic [31:0] time_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst)
         cycle_cnt <= '0;
      else
         cycle_cnt <= cycle_cnt + 32'd1;
   end

   // Each entry keeps the counter value seen at its own push edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            time_mem[i] <= '0;
      end else if (push) begin
         time_mem[wr_ptr] <= cycle_cnt;
      end
   end

   assign out_time = time_mem[rd_ptr];
`endif

   assign out_valid = (count_q != '0);
   assign full      = (count_q == DEPTH_CNT);
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign out_data  = mem[rd_ptr];

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Self-checking bench for a0_trace_fifo: vector table, corner-case sequences and random traffic vs a queue model.
// Define A0_TRACE_TIMESTAMP_EN to also exercise out_time.
module tb_a0_trace_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int PW    = $clog2(DEPTH);

   logic          clk;
   logic          rst;
   logic [DW-1:0] a0_in;
   logic          capture_en;
   logic          out_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [PW:0]   count;
   logic          full;
   logic          overflow;
`ifdef A0_TRACE_TIMESTAMP_EN
   logic [31:0]   out_time;
`endif

   a0_trace_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .a0_in(a0_in),
      .capture_en(capture_en),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .count(count),
      .full(full),
      .overflow(overflow)
`ifdef A0_TRACE_TIMESTAMP_EN
      ,
      .out_time(out_time)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        cap;
      logic [31:0] a0;
      logic        rdy;
      logic        e_valid;
      int          e_count;
      logic        e_full;
      logic        e_ovf;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: FIFO contents as queues, plus last value, sticky flag and cycle counter.
   logic [31:0] m_data[$];
   logic [31:0] m_time[$];
   logic [31:0] m_last;
   logic [31:0] m_cyc;
   logic        m_ovf;

   task automatic addVec(input logic r, input logic c, input logic [31:0] a, input logic rd,
                         input logic ev, input int ec, input logic ef, input logic eo, input logic [31:0] ed);
      vec_t v;
      v.rst = r; v.cap = c; v.a0 = a; v.rdy = rd;
      v.e_valid = ev; v.e_count = ec; v.e_full = ef; v.e_ovf = eo; v.e_data = ed;
      vecs.push_back(v);
   endtask

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic modelStep(input logic r, input logic c, input logic [31:0] a, input logic rd);
      logic was_full;
      logic do_pop;
      logic chg;
      if (r) begin
         m_data.delete();
         m_time.delete();
         m_last = '0;
         m_ovf  = 1'b0;
         m_cyc  = '0;
      end else begin
         was_full = (m_data.size() == DEPTH);
         do_pop   = (m_data.size() != 0) && rd;
         chg      = c && (a != m_last);
         if (do_pop) begin
            void'(m_data.pop_front());
            void'(m_time.pop_front());
         end
         if (chg) begin
            m_last = a;
            if (!was_full || do_pop) begin
               m_data.push_back(a);
               m_time.push_back(m_cyc);
            end else begin
               m_ovf = 1'b1;
            end
         end
         m_cyc = m_cyc + 32'd1;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic c, input logic [31:0] a, input logic rd);
      rst        = r;
      capture_en = c;
      a0_in      = a;
      out_ready  = rd;
      @(posedge clk);
      modelStep(r, c, a, rd);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, " out_valid"}, 64'(out_valid), 64'(m_data.size() != 0));
      checkVal({tag, " count"}, 64'(count), 64'(m_data.size()));
      checkVal({tag, " full"}, 64'(full), 64'(m_data.size() == DEPTH));
      checkVal({tag, " overflow"}, 64'(overflow), 64'(m_ovf));
      if (m_data.size() != 0) begin
         checkVal({tag, " out_data"}, 64'(out_data), 64'(m_data[0]));
`ifdef A0_TRACE_TIMESTAMP_EN
         checkVal({tag, " out_time"}, 64'(out_time), 64'(m_time[0]));
`endif
      end
   endtask

   initial begin
      rst = 1'b0; capture_en = 1'b0; a0_in = '0; out_ready = 1'b0;
      m_last = '0; m_cyc = '0; m_ovf = 1'b0;

      // Reset, idle at zero, then the 5,5,7,7,9 burst drained, then capture_en gating.
      addVec(1, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++)
         addVec(0, 1, 0, 0, 0, 0, 0, 0, 0);
      addVec(0, 1, 5, 0, 1, 1, 0, 0, 5);
      addVec(0, 1, 5, 0, 1, 1, 0, 0, 5);
      addVec(0, 1, 7, 0, 1, 2, 0, 0, 5);
      addVec(0, 1, 7, 0, 1, 2, 0, 0, 5);
      addVec(0, 1, 9, 0, 1, 3, 0, 0, 5);
      addVec(0, 1, 9, 1, 1, 2, 0, 0, 7);
      addVec(0, 1, 9, 1, 1, 1, 0, 0, 9);
      addVec(0, 1, 9, 1, 0, 0, 0, 0, 0);
      addVec(0, 1, 9, 1, 0, 0, 0, 0, 0);
      addVec(0, 0, 3, 0, 0, 0, 0, 0, 0);
      addVec(0, 1, 9, 0, 0, 0, 0, 0, 0);
      addVec(0, 1, 3, 0, 1, 1, 0, 0, 3);
      addVec(0, 1, 3, 1, 0, 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].cap, vecs[i].a0, vecs[i].rdy);
         checkOutput($sformatf("vec%0d model", i));
         checkVal($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
         checkVal($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].e_count));
         checkVal($sformatf("vec%0d full", i), 64'(full), 64'(vecs[i].e_full));
         checkVal($sformatf("vec%0d overflow", i), 64'(overflow), 64'(vecs[i].e_ovf));
         if (vecs[i].e_valid)
            checkVal($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vecs[i].e_data));
      end

      // Overfill with 1..17: value 17 is dropped and flagged.
      applyStimulus(1, 1, 0, 0);
      for (int v = 1; v <= 17; v++) begin
         applyStimulus(0, 1, 32'(v), 0);
         checkOutput($sformatf("fill%0d", v));
      end
      checkVal("overfill full", 64'(full), 64'd1);
      checkVal("overfill count", 64'(count), 64'd16);
      checkVal("overfill overflow", 64'(overflow), 64'd1);
      for (int v = 1; v <= 16; v++) begin
         checkVal($sformatf("drain head %0d", v), 64'(out_data), 64'(v));
         applyStimulus(0, 1, 17, 1);
         checkOutput($sformatf("drain%0d", v));
      end
      checkVal("drain empty", 64'(out_valid), 64'd0);

      // Full FIFO with simultaneous pop and push: no drop, 0xAA lands at the tail.
      applyStimulus(1, 1, 0, 0);
      for (int v = 1; v <= 16; v++)
         applyStimulus(0, 1, 32'(v), 0);
      applyStimulus(0, 1, 32'hAA, 1);
      checkOutput("full swap");
      checkVal("full swap count", 64'(count), 64'd16);
      checkVal("full swap overflow", 64'(overflow), 64'd0);
      checkVal("full swap full", 64'(full), 64'd1);
      for (int v = 2; v <= 16; v++) begin
         checkVal($sformatf("swap head %0d", v), 64'(out_data), 64'(v));
         applyStimulus(0, 1, 32'hAA, 1);
      end
      checkVal("swap tail", 64'(out_data), 64'hAA);
      applyStimulus(0, 1, 32'hAA, 1);
      checkVal("swap empty", 64'(out_valid), 64'd0);

      // Reset in the middle of a drain discards everything.
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 1, 1, 0);
      applyStimulus(0, 1, 2, 0);
      applyStimulus(0, 1, 3, 0);
      applyStimulus(0, 1, 3, 1);
      checkOutput("pre-reset");
      applyStimulus(1, 1, 3, 1);
      checkVal("midreset out_valid", 64'(out_valid), 64'd0);
      checkVal("midreset count", 64'(count), 64'd0);
      checkVal("midreset overflow", 64'(overflow), 64'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, 0);
         checkVal($sformatf("post-reset zero %0d", i), 64'(count), 64'd0);
      end

`ifdef A0_TRACE_TIMESTAMP_EN
      // Push edge lands on counter value 4: four quiet edges after reset, then the change.
      applyStimulus(1, 1, 0, 0);
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 1, 0);
      checkVal("timestamp out_time", 64'(out_time), 64'd4);
      checkVal("timestamp out_data", 64'(out_data), 64'd1);
      checkOutput("timestamp");
`endif

      // Random traffic with a small value range so repeats and full/empty are frequent.
      applyStimulus(1, 1, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         logic r;
         logic c;
         logic rd;
         r  = ($urandom_range(0, 299) == 0);
         c  = ($urandom_range(0, 9) != 0);
         rd = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         applyStimulus(r, c, 32'($urandom_range(0, 3)), rd);
         checkOutput($sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
